puf_challenge_ctrl: RTL
=======================

Name: puf_challenge_ctrl

Overview:
Sequencer for the N-stage arbiter PUF delay chain. It captures a challenge, drives the chain's select bits, clears the SR latch, launches the race edge and waits for it to settle. It then samples the synchronized latch output, repeats the measurement VOTES times and returns a majority-voted response bit. It sits between the system bus/request logic and the PUF chain and owns all PUF-facing pins.

Parameters:
N, 128, challenge width; equals PUF stage count.
VOTES, 7, measurements per challenge; must be odd and >=1.
CLR_CYC, 4, cycles the latch reset is held per measurement; >=1.
SETTLE_CYC, 16, cycles the launched edge is held before sampling; >=3, covers race settle plus 2-flop sync.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
challenge  input  N  challenge; captured on the accepted start.
busy  output  1  high from the cycle after an accepted start until the cycle resp_valid is high, inclusive.
resp_valid  output  1  one-cycle pulse; response is valid.
response  output  1  majority-voted response; held until the next resp_valid.
sel  output  N  select bits to the PUF chain.
puf_in  output  1  race launch edge to the chain input.
puf_reset  output  1  reset to the PUF SR latch.
puf_out  input  1  asynchronous SR latch output.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, resp_valid=0, response=0, sel=0, puf_in=0, puf_reset=1, vote counters=0.
- FSM states: IDLE, CLR, ARM, FIRE, SAMPLE, DONE.
- IDLE:
  - puf_reset=1, puf_in=0.
  - On start=1, capture challenge into sel, clear ones_cnt and vote_cnt, and go to CLR.
- CLR: puf_reset=1, puf_in=0 for exactly CLR_CYC cycles, then go to ARM.
- ARM: puf_reset=0, puf_in=0 for 1 cycle, then go to FIRE.
- FIRE: puf_reset=0, puf_in=1 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Add the synchronized puf_out to ones_cnt and increment vote_cnt.
  - puf_in stays 1.
  - If vote_cnt+1 < VOTES, go to CLR; otherwise go to DONE.
- DONE (1 cycle):
  - resp_valid=1, response=(final ones_cnt > VOTES/2), puf_reset=1, puf_in=0.
  - Go to IDLE.
- Latency:
  - Per measurement: CLR_CYC+1+SETTLE_CYC+1 cycles.
  - resp_valid rises VOTES*(CLR_CYC+SETTLE_CYC+2)+1 cycles after the start edge; 155 with the defaults.
- sel holds the captured challenge from the cycle after start until the next accepted start. It never changes mid-operation.
- start while busy=1 is ignored; no queueing. start in the DONE cycle is also ignored.
- puf_out passes through a 2-flop synchronizer. Only its output is used.
- Counter widths:
  - ones_cnt and vote_cnt: $clog2(VOTES+1) bits.
  - Phase timer: $clog2(max(CLR_CYC,SETTLE_CYC)+1) bits.
  - No wrap is possible.
- Reset mid-operation: next cycle returns to reset values (IDLE, puf_reset=1, puf_in=0, sel=0). No resp_valid is issued.
- Elaboration: fatal error if VOTES is even or 0, CLR_CYC<1, or SETTLE_CYC<3.

Optional Feature:
PUF_STABILITY_EN:
- When defined, adds an output port unstable (1 bit, reset 0).
- It is updated in the DONE cycle to 1 if ones_cnt is neither 0 nor VOTES (votes not unanimous), else 0.
- It is held until the next DONE.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package puf_ctrl_pkg holds:
  - the state enum (IDLE, CLR, ARM, FIRE, SAMPLE, DONE);
  - localparam helper functions for counter widths;
  - the default VOTES/CLR_CYC/SETTLE_CYC constants.
- Sub-module puf_out_sync: 2-flop synchronizer (clk, reset, d, q), with q resetting to 0.
- The FSM, timers and vote counter stay in the top.

Test Plan:
1. Defaults; model puf_out=1 constantly; start with challenge=128'hA5A5...A5.
   - sel=that value from cycle 1.
   - resp_valid single pulse at cycle 155, response=1, busy falls after that cycle.
2. Model returns 1 on measurements 1,3,5,7 only (4/7) -> response=1. Pattern 1,3,5 only (3/7) -> response=0.
3. start pulsed again at cycles 10 and 100 of an operation -> ignored: exactly one resp_valid, sel unchanged.
4. Assert reset at cycle 50 for one cycle:
   - Next cycle: busy=0, puf_reset=1, puf_in=0, sel=0.
   - No resp_valid within 200 cycles.
   - A subsequent start completes normally.
5. Phase check, first measurement:
   - puf_reset=1 for cycles 1-4.
   - puf_reset=0, puf_in=0 at cycle 5.
   - puf_in=1 for cycles 6-22.
   - Cycle 23 returns to CLR.
6. With PUF_STABILITY_EN:
   - Patterns of 7/7 and 0/7 ones -> unstable=0.
   - 5/7 -> unstable=1 and response=1.
   - Value held until the next DONE.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// puf_ctrl_pkg
// Shared definitions for the arbiter-PUF challenge controller:
//   - puf_state_t : sequencer states (IDLE, CLR, ARM, FIRE, SAMPLE, DONE)
//   - vote_cnt_w  : width of the vote / ones counters for a given vote count
//   - timer_w     : width of the phase timer covering both timed phases
//   - DEF_*       : default N / VOTES / CLR_CYC / SETTLE_CYC values
// -----------------------------------------------------------------------------
package puf_ctrl_pkg;

    localparam int DEF_N          = 128;
    localparam int DEF_VOTES      = 7;
    localparam int DEF_CLR_CYC    = 4;
    localparam int DEF_SETTLE_CYC = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ARM,
        FIRE,
        SAMPLE,
        DONE
    } puf_state_t;

    // Counter must hold the value VOTES itself (all measurements returned 1).
    function automatic int vote_cnt_w(input int votes);
        return $clog2(votes + 1);
    endfunction

    // One timer serves both CLR and FIRE, so size it for the longer phase.
    function automatic int timer_w(input int clr_cyc, input int settle_cyc);
        int longest;
        longest = (clr_cyc > settle_cyc) ? clr_cyc : settle_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/puf_out_sync.sv
// -----------------------------------------------------------------------------
// puf_out_sync
// Two-flop synchronizer for the asynchronous SR-latch output of the PUF.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; clears both stages
//   d     : asynchronous input (latch output)
//   q     : synchronized output, two clocks behind d
// -----------------------------------------------------------------------------
module puf_out_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            // stage 0: may go metastable
            meta_p0 <= d;
            // stage 1: resolved value
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/puf_challenge_ctrl.sv
// -----------------------------------------------------------------------------
// puf_challenge_ctrl
// Sequencer for an N-stage arbiter PUF. Captures a challenge onto the select
// bits, then performs VOTES measurements (clear latch, arm, launch the race
// edge, wait for settle, sample the synchronized latch output) and returns
// the majority-voted response bit.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   start      : request, accepted only while busy=0
//   challenge  : N-bit challenge, captured on the accepted start
//   busy       : high from the cycle after an accepted start through the
//                resp_valid cycle
//   resp_valid : one-cycle pulse, response valid
//   response   : majority-voted response, held until the next resp_valid
//   sel        : select bits to the PUF chain (captured challenge)
//   puf_in     : race launch edge to the chain input
//   puf_reset  : reset to the PUF SR latch
//   puf_out    : asynchronous SR latch output
//   unstable   : (PUF_STABILITY_EN only) 1 when the last vote was not unanimous
//
// Optional feature macro: PUF_STABILITY_EN adds the 'unstable' output.
// -----------------------------------------------------------------------------
module puf_challenge_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int VOTES      = DEF_VOTES,
    parameter int CLR_CYC    = DEF_CLR_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] challenge,
    output logic         busy,
    output logic         resp_valid,
    output logic         response,
    output logic [N-1:0] sel,
    output logic         puf_in,
    output logic         puf_reset,
`ifdef PUF_STABILITY_EN
    output logic         unstable,
`endif
    input  logic         puf_out
);

    localparam int CW = vote_cnt_w(VOTES);
    localparam int TW = timer_w(CLR_CYC, SETTLE_CYC);

    // Timer counts down to zero, so a phase of L cycles loads L-1.
    localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);

    if ((VOTES < 1) || ((VOTES % 2) == 0)) begin : g_bad_votes
        $fatal(1, "puf_challenge_ctrl: VOTES must be odd and >= 1");
    end
    if (CLR_CYC < 1) begin : g_bad_clr
        $fatal(1, "puf_challenge_ctrl: CLR_CYC must be >= 1");
    end
    if (SETTLE_CYC < 3) begin : g_bad_settle
        $fatal(1, "puf_challenge_ctrl: SETTLE_CYC must be >= 3");
    end

    puf_state_t    state;
    logic [TW-1:0] timer;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] vote_cnt;
    logic          sync_q;

    logic [CW-1:0] ones_next;
    logic          last_vote;
    logic          majority;

    puf_out_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (puf_out),
        .q     (sync_q)
    );

    // Values as they will be after the current SAMPLE cycle; the DONE outputs
    // are registered on the SAMPLE->DONE transition so they must include the
    // measurement being taken now.
    assign ones_next = ones_cnt + CW'(sync_q);
    assign last_vote = (int'(vote_cnt) + 1) >= VOTES;
    assign majority  = int'(ones_next) > (VOTES / 2);

`ifdef PUF_STABILITY_EN
    logic split_vote;
    assign split_vote = (ones_next != '0) && (int'(ones_next) != VOTES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            ones_cnt   <= '0;
            vote_cnt   <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= 1'b0;
            sel        <= '0;
            puf_in     <= 1'b0;
            puf_reset  <= 1'b1;
`ifdef PUF_STABILITY_EN
            unstable   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    puf_reset <= 1'b1;
                    puf_in    <= 1'b0;
                    if (start) begin
                        sel      <= challenge;
                        ones_cnt <= '0;
                        vote_cnt <= '0;
                        timer    <= CLR_LOAD;
                        busy     <= 1'b1;
                        state    <= CLR;
                    end
                end

                CLR: begin
                    if (timer == '0) begin
                        puf_reset <= 1'b0;
                        puf_in    <= 1'b0;
                        state     <= ARM;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ARM: begin
                    puf_in <= 1'b1;
                    timer  <= SETTLE_LOAD;
                    state  <= FIRE;
                end

                // puf_in stays high through FIRE and SAMPLE.
                FIRE: begin
                    if (timer == '0) begin
                        state <= SAMPLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                SAMPLE: begin
                    ones_cnt  <= ones_next;
                    vote_cnt  <= vote_cnt + CW'(1);
                    puf_reset <= 1'b1;
                    puf_in    <= 1'b0;
                    if (last_vote) begin
                        resp_valid <= 1'b1;
                        response   <= majority;
`ifdef PUF_STABILITY_EN
                        unstable   <= split_vote;
`endif
                        state      <= DONE;
                    end else begin
                        timer <= CLR_LOAD;
                        state <= CLR;
                    end
                end

                // start is not looked at here; it is dropped like any busy start.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    puf_reset <= 1'b1;
                    puf_in    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
